fosfor_present_ctrl: RTL and testbench

Sequencing controller for the PRESENT-80 encryption datapath inside the Tiny Tapeout top. It accepts plaintext and key as nibble streams through the narrow pin interface and steps the datapath through 31 rounds plus the final key addition. It then hands the ciphertext back out nibble by nibble over a valid/ready handshake. It contains no cipher logic; it drives only the datapath's enables and round counter.

---
 rtl/fosfor_present_ctrl.sv | 133 +++++++++++++
 tb/tb_fosfor_present_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fosfor_present_ctrl.sv
// Sequencing controller for the PRESENT-80 datapath: nibble loading, 31 rounds,
// final key addition and nibble-wise ciphertext output over valid/ready.
module fosfor_present_ctrl #(
  parameter int ROUNDS        = 31,
  parameter int STATE_NIBBLES = 16,
  parameter int KEY_NIBBLES   = 20
) (
  input  logic       Clk_k,
  input  logic       Reset_rn,
  input  logic       InValid_i,
  input  logic       InSel_i,
  input  logic       Start_i,
  input  logic       OutReady_i,
  output logic       InReady_o,
  output logic       StateShiftEn_o,
  output logic       KeyShiftEn_o,
  output logic       StateFull_o,
  output logic       KeyFull_o,
  output logic       RoundEn_o,
  output logic [4:0] RoundCnt_ob,
  output logic       FinalAddEn_o,
  output logic       OutValid_o,
  output logic       OutShiftEn_o,
  output logic       Busy_o,
  output logic       Done_o
);

  localparam logic [4:0] ROUND_LAST = 5'(ROUNDS);
  localparam logic [3:0] STATE_LAST = 4'(STATE_NIBBLES - 1);
  localparam logic [4:0] KEY_LAST   = 5'(KEY_NIBBLES - 1);
  localparam logic [3:0] OUT_LAST   = 4'(STATE_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, OUTPUT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] state_cnt_reg;
  logic [4:0] key_cnt_reg;
  logic [3:0] out_cnt_reg;
  logic [4:0] round_cnt_reg;
  logic       state_full_reg, key_full_reg;
  logic       in_ready_reg, round_en_reg, final_reg, out_valid_reg, busy_reg, done_reg;

  logic idle, state_accept, key_accept, start_ok, out_hs, out_last;

  assign idle         = (state_reg == IDLE);
  assign state_accept = idle & InValid_i & ~InSel_i;
  assign key_accept   = idle & InValid_i & InSel_i;
  // A load nibble in the same cycle blocks Start_i.
  assign start_ok     = idle & Start_i & ~InValid_i & state_full_reg & key_full_reg;
  assign out_hs       = (state_reg == OUTPUT) & OutReady_i;
  assign out_last     = out_hs & (out_cnt_reg == OUT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (round_cnt_reg == ROUND_LAST) state_next = FINAL;
      FINAL:   state_next = OUTPUT;
      OUTPUT:  if (out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      state_reg      <= IDLE;
      state_cnt_reg  <= '0;
      key_cnt_reg    <= '0;
      out_cnt_reg    <= '0;
      round_cnt_reg  <= '0;
      state_full_reg <= 1'b0;
      key_full_reg   <= 1'b0;
      in_ready_reg   <= 1'b1;
      round_en_reg   <= 1'b0;
      final_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == IDLE);
      round_en_reg  <= (state_next == RUN);
      final_reg     <= (state_next == FINAL);
      out_valid_reg <= (state_next == OUTPUT);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= out_last;

      // Counters saturate once full; the datapath simply keeps the newest nibbles.
      if (state_accept && !state_full_reg) begin
        if (state_cnt_reg == STATE_LAST) state_full_reg <= 1'b1;
        else                             state_cnt_reg  <= state_cnt_reg + 4'd1;
      end
      if (key_accept && !key_full_reg) begin
        if (key_cnt_reg == KEY_LAST) key_full_reg <= 1'b1;
        else                         key_cnt_reg  <= key_cnt_reg + 5'd1;
      end

      if (start_ok) begin
        round_cnt_reg <= 5'd1;
      end else if (state_reg == RUN && round_cnt_reg != ROUND_LAST) begin
        round_cnt_reg <= round_cnt_reg + 5'd1;
      end

      if (out_hs) begin
        out_cnt_reg <= out_cnt_reg + 4'd1;
      end

      // The key schedule has consumed the key, so both operands must be reloaded.
      if (out_last) begin
        state_cnt_reg  <= '0;
        key_cnt_reg    <= '0;
        out_cnt_reg    <= '0;
        round_cnt_reg  <= '0;
        state_full_reg <= 1'b0;
        key_full_reg   <= 1'b0;
      end
    end
  end

  assign InReady_o      = in_ready_reg;
  assign StateShiftEn_o = state_accept;
  assign KeyShiftEn_o   = key_accept;
  assign StateFull_o    = state_full_reg;
  assign KeyFull_o      = key_full_reg;
  assign RoundEn_o      = round_en_reg;
  assign RoundCnt_ob    = round_cnt_reg;
  assign FinalAddEn_o   = final_reg;
  assign OutValid_o     = out_valid_reg;
  assign OutShiftEn_o   = out_hs;
  assign Busy_o         = busy_reg;
  assign Done_o         = done_reg;

endmodule

// File: tb/tb_fosfor_present_ctrl.sv
// Randomized bench for fosfor_present_ctrl against a cycle-count reference model
// (cycles since start, handshake count, nibbles loaded).
module tb_fosfor_present_ctrl;

  logic       Clk_k = 1'b0;
  logic       Reset_rn = 1'b1;
  logic       InValid_i = 1'b0, InSel_i = 1'b0, Start_i = 1'b0, OutReady_i = 1'b0;
  logic       InReady_o, StateShiftEn_o, KeyShiftEn_o, StateFull_o, KeyFull_o;
  logic       RoundEn_o, FinalAddEn_o, OutValid_o, OutShiftEn_o, Busy_o, Done_o;
  logic [4:0] RoundCnt_ob;

  fosfor_present_ctrl dut (
    .Clk_k          (Clk_k),
    .Reset_rn       (Reset_rn),
    .InValid_i      (InValid_i),
    .InSel_i        (InSel_i),
    .Start_i        (Start_i),
    .OutReady_i     (OutReady_i),
    .InReady_o      (InReady_o),
    .StateShiftEn_o (StateShiftEn_o),
    .KeyShiftEn_o   (KeyShiftEn_o),
    .StateFull_o    (StateFull_o),
    .KeyFull_o      (KeyFull_o),
    .RoundEn_o      (RoundEn_o),
    .RoundCnt_ob    (RoundCnt_ob),
    .FinalAddEn_o   (FinalAddEn_o),
    .OutValid_o     (OutValid_o),
    .OutShiftEn_o   (OutShiftEn_o),
    .Busy_o         (Busy_o),
    .Done_o         (Done_o)
  );

  always #5 Clk_k = ~Clk_k;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int os_cnt, done_seen, done_cyc;

  // Reference model: busy flag, cycles since start accepted, handshakes, nibbles loaded.
  bit m_busy = 1'b0;
  int m_d    = 0;
  int m_hs   = 0;
  int m_st   = 0;
  int m_key  = 0;
  bit m_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit idle, out_ph;
    int rc;
    idle   = !m_busy;
    out_ph = m_busy && (m_d >= 33);
    rc     = !m_busy ? 0 : ((m_d <= 31) ? m_d : 31);
    check_eq("in_ready",    32'(InReady_o),      32'(idle));
    check_eq("state_shift", 32'(StateShiftEn_o), 32'(idle & InValid_i & ~InSel_i));
    check_eq("key_shift",   32'(KeyShiftEn_o),   32'(idle & InValid_i & InSel_i));
    check_eq("state_full",  32'(StateFull_o),    32'(m_st >= 16));
    check_eq("key_full",    32'(KeyFull_o),      32'(m_key >= 20));
    check_eq("round_en",    32'(RoundEn_o),      32'(m_busy && m_d <= 31));
    check_eq("round_cnt",   32'(RoundCnt_ob),    32'(rc));
    check_eq("final_add",   32'(FinalAddEn_o),   32'(m_busy && m_d == 32));
    check_eq("out_valid",   32'(OutValid_o),     32'(out_ph));
    check_eq("out_shift",   32'(OutShiftEn_o),   32'(out_ph & OutReady_i));
    check_eq("busy",        32'(Busy_o),         32'(m_busy));
    check_eq("done",        32'(Done_o),         32'(m_done));
  endtask

  task automatic model_step();
    bit nd;
    nd = m_busy && (m_d >= 33) && OutReady_i && (m_hs == 15);
    if (!m_busy) begin
      if (InValid_i) begin
        if (InSel_i) m_key++;
        else         m_st++;
      end else if (Start_i && m_st >= 16 && m_key >= 20) begin
        m_busy = 1'b1;
        m_d    = 1;
      end
    end else if (m_d >= 33) begin
      if (OutReady_i) begin
        m_hs++;
        if (m_hs == 16) begin
          m_busy = 1'b0;
          m_st   = 0;
          m_key  = 0;
          m_hs   = 0;
          m_d    = 0;
        end
      end
    end else begin
      m_d++;
    end
    m_done = nd;
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance one clock.
  task automatic run_cycle(input bit v, input bit sel, input bit st, input bit rdy);
    InValid_i  = v;
    InSel_i    = sel;
    Start_i    = st;
    OutReady_i = rdy;
    #2;
    check_outputs();
    if (OutShiftEn_o) os_cnt++;
    if (Done_o) begin
      done_seen++;
      done_cyc = cyc;
    end
    @(posedge Clk_k);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    InValid_i  = 1'b0;
    InSel_i    = 1'b0;
    Start_i    = 1'b0;
    OutReady_i = 1'b0;
    Reset_rn   = 1'b0;
    m_busy = 1'b0; m_d = 0; m_hs = 0; m_st = 0; m_key = 0; m_done = 1'b0;
    #2;
    check_outputs();
    #2;
    Reset_rn = 1'b1;
    @(posedge Clk_k);
    cyc++;
    #1;
  endtask

  task automatic load(input int ns, input int nk);
    bit sel;
    while (ns > 0 || nk > 0) begin
      if ($urandom_range(3) == 0) begin
        run_cycle(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      end else begin
        if (ns == 0)      sel = 1'b1;
        else if (nk == 0) sel = 1'b0;
        else              sel = 1'($urandom_range(1));
        if (sel) nk--;
        else     ns--;
        run_cycle(1'b1, sel, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end
  endtask

  // mode 0: OutReady held high, 1: pattern 1,0,0,..., 2: random
  task automatic encrypt(input int mode);
    int t0, b;
    bit rdy;
    os_cnt    = 0;
    done_seen = 0;
    done_cyc  = -1;
    t0 = cyc;
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    b = 0;
    while (m_busy && b < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (b % 3) == 0;
        default: rdy = 1'($urandom_range(1));
      endcase
      run_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), rdy);
      b++;
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("timeout",     32'(b < 400), 32'd1);
    check_eq("out_pulses",  32'(os_cnt),  32'd16);
    check_eq("done_pulses", 32'(done_seen), 32'd1);
    if (mode == 0) check_eq("latency", 32'(done_cyc - t0), 32'd49);
    $display("encrypt mode=%0d start=%0d done=%0d out_pulses=%0d", mode, t0, done_cyc, os_cnt);
  endtask

  task automatic abort_run();
    int b;
    load(16, 20);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    b = 0;
    while (m_d < 17 && b < 100) begin
      run_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      b++;
    end
    check_eq("abort_round", 32'(RoundCnt_ob), 32'd17);
    reset_dut();
    repeat (4) run_cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1);
    $display("abort at round 17, cycle %0d", cyc);
  endtask

  initial begin
    #6;
    reset_dut();
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    $display("reset done, cycle %0d", cyc);

    load(16, 20);
    encrypt(0);

    // Start refused with 15 state nibbles, and refused when a nibble arrives with it.
    load(15, 20);
    repeat (3) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    $display("refused starts checked, cycle %0d", cyc);
    load(3, 2);
    encrypt(1);

    load(16, 20);
    encrypt(2);

    abort_run();
    load(16, 20);
    encrypt(0);

    for (int i = 0; i < 3; i++) begin
      load(16 + $urandom_range(3), 20 + $urandom_range(3));
      encrypt($urandom_range(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
